cache_req_arbiter: RTL
======================

# cache_req_arbiter

Single-owner arbiter sitting in front of `cache_controller`, sharing its one request port between the local CPU request channel and the ACE snoop channel from the interconnect. It accepts at most one request at a time, gives snoops priority with a bounded CPU-starvation guarantee, issues the winner to the controller, and holds ownership until the controller signals `cache_complete`.

## Interface
- `ADDR_W`, 32, request address width
- `STARVE_MAX`, 4, consecutive snoop wins over a waiting CPU before the CPU is forced through (1..15)

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `cpu_valid`  in  1  CPU request pending; held until `cpu_ready`
- `cpu_op`  in  2  00 read, 01 write; others reserved
- `cpu_addr`  in  ADDR_W  CPU request address
- `cpu_ready`  out  1  CPU request accepted this cycle
- `snp_valid`  in  1  snoop pending; held until `snp_ready`
- `snp_op`  in  2  00 ReadShared, 01 ReadUnique, 10 MakeInvalid; 11 reserved
- `snp_addr`  in  ADDR_W  snoop address
- `snp_ready`  out  1  snoop accepted this cycle
- `cache_ready`  in  1  controller idle and able to take a request
- `cache_complete`  in  1  one-cycle pulse: current request finished
- `ctl_valid`  out  1  one-cycle issue strobe to controller
- `ctl_src`  out  1  0 CPU, 1 snoop (drives `write_from_cpu` / `write_from_interconnect` selection)
- `ctl_op`  out  2  latched op of granted request
- `ctl_addr`  out  ADDR_W  latched address of granted request
- `busy`  out  1  high in ISSUE and WAIT

## Operation
- States: IDLE, ISSUE, WAIT (`arb_state_e`).
- IDLE: if `cache_ready` and any valid, select winner, assert its ready combinationally, latch src/op/addr, go ISSUE. Otherwise stay.
- Selection: only one valid -> it wins. Both valid -> snoop wins unless `starve_cnt == STARVE_MAX`, then CPU wins.
- `starve_cnt` (4 bit): +1 on every IDLE acceptance where snoop wins while `cpu_valid` is high; cleared when CPU is granted; saturates at STARVE_MAX; unchanged otherwise.
- ISSUE: `ctl_valid`=1 for exactly this cycle, go WAIT unconditionally.
- WAIT: hold `ctl_src/op/addr` stable; on `cache_complete` go IDLE.
- `cache_complete` in IDLE or ISSUE is ignored (no state change, no error).
- Reserved op encodings are passed through unchanged; legality is the controller's concern.
- `cpu_ready`/`snp_ready` are never both high; neither is high outside IDLE or when `cache_ready`=0.

## Timing
- Reset (synchronous, sampled at posedge): state IDLE, `starve_cnt`=0, `ctl_valid`=0, `ctl_src`=0, `ctl_op`=0, `ctl_addr`=0, `busy`=0; ready outputs 0 while `reset`=1.
- Reset asserted in ISSUE or WAIT aborts the transaction; controller is reset on the same signal.
- Accept in cycle N (ready high) -> `ctl_valid` and `busy` in N+1 -> WAIT from N+2.
- `cache_complete` sampled at cycle M in WAIT -> IDLE at M+1; next accept possible at M+1 (minimum 3-cycle request spacing).
- Ready outputs are combinational from state, `cache_ready`, valids and `starve_cnt`; no combinational path from `cache_complete` to any output.
- Requester changing op/addr while valid and not ready is a protocol violation; behaviour undefined.

## Structure
- `cache_pkg`: `arb_state_e` {IDLE, ISSUE, WAIT}, `req_src_e` {SRC_CPU, SRC_SNP}, `cpu_op_e`, `snp_op_e` encodings, shared with `cache_controller`.
- Single flat module; starvation counter and FSM inline, no sub-module.

## Test plan
- Reset: hold `reset`=1 two cycles with both valids high -> all outputs 0, no ready; release -> snoop accepted first cycle with `cache_ready`=1.
- CPU read alone: `cpu_valid`=1, op 00, addr 0x1000 -> `cpu_ready` cycle N, `ctl_valid`=1/`ctl_src`=0/`ctl_addr`=0x1000 at N+1, `busy` until cycle after `cache_complete`.
- Contention/starvation, STARVE_MAX=4: both valid continuously, complete 2 cycles after each issue -> grant sequence S,S,S,S,C,S,S,S,S,C.
- `cache_ready`=0 with both valid -> no ready, state IDLE; raise `cache_ready` -> snoop accepted same cycle.
- Spurious `cache_complete` in ISSUE -> ignored, still WAIT; real complete in WAIT -> IDLE next cycle, back-to-back accept.
- Reset in WAIT (op 10, addr 0xBEEF0) -> next cycle IDLE, `ctl_*` cleared, `starve_cnt`=0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared encodings for the cache request arbiter and cache controller:
// arbiter FSM states, request source and the CPU/snoop op codes.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_SNP = 1'b1
    } req_src_e;

    // 2'b10 and 2'b11 are reserved and passed through untouched.
    typedef enum logic [1:0] {
        CPU_READ  = 2'b00,
        CPU_WRITE = 2'b01
    } cpu_op_e;

    typedef enum logic [1:0] {
        SNP_READ_SHARED  = 2'b00,
        SNP_READ_UNIQUE  = 2'b01,
        SNP_MAKE_INVALID = 2'b10
    } snp_op_e;

    localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/cache_req_arbiter.sv
// Single-owner arbiter in front of cache_controller: snoops win over the CPU
// unless the CPU has lost STARVE_MAX times in a row; ownership held until complete.
module cache_req_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_valid,
    input  logic [1:0]          cpu_op,
    input  logic [ADDR_W-1:0]   cpu_addr,
    output logic                cpu_ready,
    input  logic                snp_valid,
    input  logic [1:0]          snp_op,
    input  logic [ADDR_W-1:0]   snp_addr,
    output logic                snp_ready,
    input  logic                cache_ready,
    input  logic                cache_complete,
    output logic                ctl_valid,
    output logic                ctl_src,
    output logic [1:0]          ctl_op,
    output logic [ADDR_W-1:0]   ctl_addr,
    output logic                busy,
    output arb_state_e          dbg_state,
    output logic [STARVE_W-1:0] dbg_starve_cnt
);

    // Handshake: a request transfers in the cycle where its valid and ready
    // are both high; ready is only ever raised in IDLE with cache_ready set.

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                ctl_src_q, ctl_src_d;
    logic [1:0]          ctl_op_q, ctl_op_d;
    logic [ADDR_W-1:0]   ctl_addr_q, ctl_addr_d;
    logic                cpu_wins;

    assign cpu_wins = cpu_valid && (!snp_valid || (starve_cnt_q == STARVE_LIM));

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        ctl_src_d    = ctl_src_q;
        ctl_op_d     = ctl_op_q;
        ctl_addr_d   = ctl_addr_q;
        cpu_ready    = 1'b0;
        snp_ready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // reset gating keeps ready low even before the state flop settles
                if (!reset && cache_ready && (cpu_valid || snp_valid)) begin
                    state_d = ISSUE;
                    if (cpu_wins) begin
                        cpu_ready    = 1'b1;
                        ctl_src_d    = SRC_CPU;
                        ctl_op_d     = cpu_op;
                        ctl_addr_d   = cpu_addr;
                        starve_cnt_d = '0;
                    end else begin
                        snp_ready  = 1'b1;
                        ctl_src_d  = SRC_SNP;
                        ctl_op_d   = snp_op;
                        ctl_addr_d = snp_addr;
                        if (cpu_valid && (starve_cnt_q < STARVE_LIM)) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (cache_complete) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            ctl_src_q    <= 1'b0;
            ctl_op_q     <= '0;
            ctl_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            ctl_src_q    <= ctl_src_d;
            ctl_op_q     <= ctl_op_d;
            ctl_addr_q   <= ctl_addr_d;
        end
    end

    assign ctl_valid      = (state_q == ISSUE);
    assign busy           = (state_q != IDLE);
    assign ctl_src        = ctl_src_q;
    assign ctl_op         = ctl_op_q;
    assign ctl_addr       = ctl_addr_q;
    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt_q;

endmodule
